// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer slice.
//   - byte / field widths of the 4-byte instruction format
//   - opcode encodings (byte0[7:6])
//   - sequencer state type
package fetch_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = 4;
   localparam int unsigned OPC_W     = 2;
   localparam int unsigned FIELD_W   = 6;
   localparam int unsigned PAYLOAD_W = 24;

   localparam logic [OPC_W-1:0] OPC_NORMAL = 2'b00;
   localparam logic [OPC_W-1:0] OPC_JUMP   = 2'b01;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 2'b10;
   localparam logic [OPC_W-1:0] OPC_HALT   = 2'b11;

   // F0..F3 occupy codes 0..3 so the low two bits double as the byte index
   typedef enum logic [2:0] {
      ST_F0     = 3'd0,
      ST_F1     = 3'd1,
      ST_F2     = 3'd2,
      ST_F3     = 3'd3,
      ST_ISSUE  = 3'd4,
      ST_UPDATE = 3'd5,
      ST_HALT   = 3'd6
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction handshake between the fetch sequencer
// (master) and the execute stage (slave).
//   instr_valid/instr_ready : valid/ready handshake
//   instr_opcode/field/payload : assembled instruction
//   branch_cond             : branch flag from execute, sampled at handshake
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic                 instr_valid;
   logic                 instr_ready;
   logic                 branch_cond;
   logic [OPC_W-1:0]     instr_opcode;
   logic [FIELD_W-1:0]   instr_field;
   logic [PAYLOAD_W-1:0] instr_payload;

   modport master (
      output instr_valid, instr_opcode, instr_field, instr_payload,
      input  instr_ready, branch_cond
   );

   modport slave (
      input  instr_valid, instr_opcode, instr_field, instr_payload,
      output instr_ready, branch_cond
   );

endinterface

// File: rtl/fetch_sequencer_assembler.sv
// instr_byte_assembler: four byte capture registers for one instruction.
//   clk, rst          : clock, synchronous active-high clear
//   wr_en, wr_idx     : capture wr_data into byte register wr_idx
//   opcode/field      : byte0[7:6] / byte0[5:0]
//   payload           : {byte1, byte2, byte3}
module instr_byte_assembler
   import fetch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [1:0]           wr_idx,
   input  logic [BYTE_W-1:0]    wr_data,
   output logic [OPC_W-1:0]     opcode,
   output logic [FIELD_W-1:0]   field,
   output logic [PAYLOAD_W-1:0] payload
);

   logic [BYTE_W-1:0] byte_q [NUM_BYTES];

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_q <= '{default: '0};
      end else if (wr_en) begin
         byte_q[wr_idx] <= wr_data;
      end
   end

   assign opcode  = byte_q[0][7:6];
   assign field   = byte_q[0][5:0];
   assign payload = {byte_q[1], byte_q[2], byte_q[3]};

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: assembles 4-byte instructions from the PC-addressed
// memory, presents them to execute, then pulses one PC control.
//   clk, rst          : clock, synchronous active-high reset
//   exe               : instruction handshake (master side)
//   mem_data          : byte at the PC's current address
//   update_lsbs/msbs  : PC byte / word advance
//   jump, jump_destination   : PC absolute word jump
//   branch, branch_offset    : PC relative word branch (two's complement)
//   halted            : HALT retired; cleared only by rst
module fetch_sequencer
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fetch_sequencer_if.master  exe,
   input  logic [BYTE_W-1:0]  mem_data,
   output logic               update_lsbs,
   output logic               update_msbs,
   output logic               jump,
   output logic [FIELD_W-1:0] jump_destination,
   output logic               branch,
   output logic [FIELD_W-1:0] branch_offset,
   output logic               halted
);

   fetch_state_t         state;
   logic                 valid_q;
   logic                 wr_en;
   logic [1:0]           wr_idx;
   logic [OPC_W-1:0]     opcode;
   logic [FIELD_W-1:0]   field;
   logic [PAYLOAD_W-1:0] payload;

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = '0;
      case (state)
         ST_F0:   begin wr_en = 1'b1; wr_idx = 2'd0; end
         ST_F1:   begin wr_en = 1'b1; wr_idx = 2'd1; end
         ST_F2:   begin wr_en = 1'b1; wr_idx = 2'd2; end
         ST_F3:   begin wr_en = 1'b1; wr_idx = 2'd3; end
         default: begin wr_en = 1'b0; wr_idx = '0;   end
      endcase
   end

   instr_byte_assembler u_asm (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (mem_data),
      .opcode  (opcode),
      .field   (field),
      .payload (payload)
   );

   // Outputs are registered alongside the state: each branch loads the
   // values belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_F0;
         valid_q          <= 1'b0;
         update_lsbs      <= 1'b1;
         update_msbs      <= 1'b0;
         jump             <= 1'b0;
         jump_destination <= '0;
         branch           <= 1'b0;
         branch_offset    <= '0;
         halted           <= 1'b0;
      end else begin
         case (state)
            ST_F0: state <= ST_F1;
            ST_F1: state <= ST_F2;
            ST_F2: state <= ST_F3;
            ST_F3: begin
               state       <= ST_ISSUE;
               update_lsbs <= 1'b0;
               valid_q     <= 1'b1;
            end
            ST_ISSUE: begin
               if (exe.instr_ready) begin
                  valid_q <= 1'b0;
                  if (opcode == OPC_HALT) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= ST_UPDATE;
                     if (opcode == OPC_JUMP) begin
                        jump             <= 1'b1;
                        jump_destination <= field;
                     end else if (opcode == OPC_BRANCH && exe.branch_cond) begin
                        branch        <= 1'b1;
                        branch_offset <= field;
                     end else begin
                        update_msbs <= 1'b1;
                     end
                  end
               end
            end
            ST_UPDATE: begin
               state            <= ST_F0;
               update_lsbs      <= 1'b1;
               update_msbs      <= 1'b0;
               jump             <= 1'b0;
               jump_destination <= '0;
               branch           <= 1'b0;
               branch_offset    <= '0;
            end
            ST_HALT: state <= ST_HALT;
            default: begin
               state       <= ST_F0;
               valid_q     <= 1'b0;
               update_lsbs <= 1'b1;
               update_msbs <= 1'b0;
               jump        <= 1'b0;
               branch      <= 1'b0;
            end
         endcase
      end
   end

   assign exe.instr_valid   = valid_q;
   assign exe.instr_opcode  = opcode;
   assign exe.instr_field   = field;
   assign exe.instr_payload = payload;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC and 256-byte memory.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] mem_data;
   logic       update_lsbs, update_msbs, jump, branch, halted;
   logic [5:0] jump_destination, branch_offset;
   logic [7:0] pc;
   logic [7:0] mem [256];

   int tests = 0;
   int fails = 0;
   int n;

   fetch_sequencer_if exe_if ();

   fetch_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .exe              (exe_if),
      .mem_data         (mem_data),
      .update_lsbs      (update_lsbs),
      .update_msbs      (update_msbs),
      .jump             (jump),
      .jump_destination (jump_destination),
      .branch           (branch),
      .branch_offset    (branch_offset),
      .halted           (halted)
   );

   always #5 clk = ~clk;

   // PC model: address = {word[5:0], byte[1:0]}
   always_ff @(posedge clk) begin
      if (rst)
         pc <= '0;
      else if (jump)
         pc <= {jump_destination, 2'b00};
      else if (branch)
         pc <= {pc[7:2] + branch_offset, pc[1:0]};
      else
         pc <= {pc[7:2] + {5'b0, update_msbs}, pc[1:0] + {1'b0, update_lsbs}};
   end

   assign mem_data = mem[pc];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (exe_if.instr_valid !== 1'b1 && cnt < 20) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h05; mem[8'h01] = 8'hAA; mem[8'h02] = 8'hBB; mem[8'h03] = 8'hCC;
      mem[8'h04] = 8'h4F; mem[8'h05] = 8'h01; mem[8'h06] = 8'h02; mem[8'h07] = 8'h03;
      mem[8'h3C] = 8'hBF; mem[8'h3D] = 8'h11; mem[8'h3E] = 8'h22; mem[8'h3F] = 8'h33;
      mem[8'h38] = 8'h00; mem[8'h39] = 8'h12; mem[8'h3A] = 8'h34; mem[8'h3B] = 8'h56;
      mem[8'h40] = 8'hC0;

      rst = 1'b1;
      exe_if.instr_ready = 1'b0;
      exe_if.branch_cond = 1'b0;
      step(); step();
      check("rst_lsbs", update_lsbs, 1);
      check("rst_valid", exe_if.instr_valid, 0);
      check("rst_ctrl", {update_msbs, jump, branch, halted}, 0);
      check("rst_dest_off", {jump_destination, branch_offset}, 0);

      // run into F2, then reset mid-fetch
      rst = 1'b0;
      step(); step();
      check("midf2_addr", pc, 8'h02);
      rst = 1'b1;
      step();
      check("midrst_valid", exe_if.instr_valid, 0);
      check("midrst_lsbs", update_lsbs, 1);
      check("midrst_addr", pc, 8'h00);
      check("midrst_bytes", {exe_if.instr_field, exe_if.instr_payload}, 0);

      // NORMAL
      rst = 1'b0;
      exe_if.instr_ready = 1'b1;
      wait_valid(n);
      check("norm_latency", n, 4);
      check("norm_opc", exe_if.instr_opcode, 2'b00);
      check("norm_field", exe_if.instr_field, 6'h05);
      check("norm_payload", exe_if.instr_payload, 24'hAABBCC);
      check("norm_lsbs_off", update_lsbs, 0);
      step();
      check("norm_pulse", {update_lsbs, update_msbs, jump, branch}, 4'b0100);
      check("norm_valid_drop", exe_if.instr_valid, 0);
      step();
      check("norm_pulse_end", {update_lsbs, update_msbs, jump, branch}, 4'b1000);
      check("norm_next_addr", pc, 8'h04);

      // JUMP to word 0x0F
      wait_valid(n);
      check("jump_latency", n, 4);
      check("jump_opc", exe_if.instr_opcode, 2'b01);
      step();
      check("jump_pulse", {update_lsbs, update_msbs, jump, branch}, 4'b0010);
      check("jump_dest", jump_destination, 6'h0F);
      step();
      check("jump_end", jump, 0);
      check("jump_addr", pc, 8'h3C);

      // BRANCH taken, offset -1
      exe_if.branch_cond = 1'b1;
      wait_valid(n);
      check("brt_opc", exe_if.instr_opcode, 2'b10);
      check("brt_payload", exe_if.instr_payload, 24'h112233);
      step();
      exe_if.branch_cond = 1'b0;
      check("brt_pulse", {update_lsbs, update_msbs, jump, branch}, 4'b0001);
      check("brt_offset", branch_offset, 6'h3F);
      step();
      check("brt_end", branch, 0);
      check("brt_addr", pc, 8'h38);

      // Backpressure on the NORMAL at 0x38
      exe_if.instr_ready = 1'b0;
      wait_valid(n);
      check("bp_latency", n, 4);
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_valid", exe_if.instr_valid, 1);
         check("bp_fields", {exe_if.instr_opcode, exe_if.instr_field, exe_if.instr_payload}, 32'h00123456);
         check("bp_ctrl", {update_lsbs, update_msbs, jump, branch}, 0);
         check("bp_addr", pc, 8'h38);
      end
      exe_if.instr_ready = 1'b1;
      step();
      check("bp_pulse", {update_lsbs, update_msbs, jump, branch}, 4'b0100);
      step();
      check("bp_next_addr", pc, 8'h3C);

      // BRANCH not taken
      exe_if.branch_cond = 1'b0;
      wait_valid(n);
      check("brn_opc", exe_if.instr_opcode, 2'b10);
      step();
      check("brn_pulse", {update_lsbs, update_msbs, jump, branch}, 4'b0100);
      step();
      check("brn_no_branch", branch, 0);
      check("brn_addr", pc, 8'h40);

      // HALT
      wait_valid(n);
      check("halt_opc", exe_if.instr_opcode, 2'b11);
      step();
      check("halt_set", halted, 1);
      for (int k = 0; k < 20; k++) begin
         check("halt_quiet", {halted, exe_if.instr_valid, update_lsbs, update_msbs, jump, branch}, 6'b100000);
         step();
      end
      check("halt_addr", pc, 8'h40);

      // Reset leaves HALT, fetch resumes at 0x00
      rst = 1'b1;
      step();
      check("unhalt", halted, 0);
      check("unhalt_lsbs", update_lsbs, 1);
      rst = 1'b0;
      wait_valid(n);
      check("resume_latency", n, 4);
      check("resume_field", exe_if.instr_field, 6'h05);

      // rst with instr_ready in ISSUE: reset wins, no PC pulse
      rst = 1'b1;
      step();
      check("rst_ready_ctrl", {update_lsbs, update_msbs, jump, branch}, 4'b1000);
      check("rst_ready_valid", exe_if.instr_valid, 0);
      check("rst_ready_addr", pc, 8'h00);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing controller that drives `program_counter_v1` and consumes the bytes memory returns at its `mem_addr`. It does three things:
- assembles each 4-byte instruction by stepping the PC's two address LSBs;
- hands the instruction to the execute stage with a valid/ready handshake;
- issues exactly one PC control pulse (advance, jump or branch) per instruction.

It sits between instruction memory/PC and the execute stage.

## Interface
Parameters:
- none; widths are fixed by the PC address format (6-bit word index, 2-bit byte index).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high. The top level drives the PC's `rst_n` as `~rst`.
- `mem_data`  in  8  byte at the current PC `mem_addr`; combinational memory read, valid in the same cycle.
- `branch_cond`  in  1  branch condition flag from execute, sampled at the handshake edge.
- `instr_ready`  in  1  execute stage accepts the instruction.
- `instr_valid`  out  1  an assembled instruction is presented.
- `instr_opcode`  out  2  byte0[7:6].
- `instr_field`  out  6  byte0[5:0]; jump destination or signed branch offset.
- `instr_payload`  out  24  {byte1, byte2, byte3}.
- `update_lsbs`  out  1  to PC; advance the byte index.
- `update_msbs`  out  1  to PC; advance the word index.
- `jump`  out  1  to PC.
- `jump_destination`  out  6  to PC.
- `branch`  out  1  to PC.
- `branch_offset`  out  6  to PC; two's complement.
- `halted`  out  1  HALT opcode retired.

## Operation
- Opcodes:
  - `00` NORMAL
  - `01` JUMP
  - `10` BRANCH (taken if `branch_cond`=1)
  - `11` HALT
- Byte 0 is the lowest byte address and the most significant byte of the instruction.
- FSM states:
  - F0, F1, F2, F3:
    - `update_lsbs`=1 in each.
    - `mem_data` is captured into byte register k at the exiting edge.
    - F3 exits to ISSUE; the PC byte index wraps 3→0 on that same edge.
  - ISSUE:
    - `instr_valid`=1.
    - Stays in ISSUE until `instr_ready`=1.
    - On the handshake edge, opcode and `branch_cond` are latched and the state moves to UPDATE, or to HALT for opcode 11.
  - UPDATE (one cycle, then F0):
    - NORMAL or not-taken BRANCH: `update_msbs`=1.
    - JUMP: `jump`=1 with `jump_destination`=field.
    - Taken BRANCH: `branch`=1 with `branch_offset`=field.
  - HALT:
    - `halted`=1.
    - All PC controls stay 0.
    - Left only by `rst`.
- PC controls are Moore outputs of the state and registered fields. At most one of `update_msbs`, `jump`, `branch` is high in any cycle. `update_lsbs` is never high together with any of them.
- `instr_opcode`, `instr_field` and `instr_payload` hold stable throughout ISSUE, whatever `instr_ready` does. Outside ISSUE they hold the last assembled value.

## Timing
- Reset:
  - State F0, byte registers 0.
  - Every output 0 except `update_lsbs`, which is 1 because F0 is active.
- Reset asserted mid-fetch or mid-ISSUE: the next state is F0 and partial bytes are discarded. The PC resets to 0x00 on the same edge.
- Latency:
  - 4 cycles fetch, then ISSUE for at least 1 cycle.
  - Minimum instruction period is 6 cycles: `instr_valid` rises 4 cycles after F0 entry.
- `instr_ready` already high on entry to ISSUE: the handshake completes in that first ISSUE cycle.
- `branch_cond` changing after the handshake edge has no effect.
- `rst` and `instr_ready` together: reset wins and no PC pulse is issued.

## Structure
- Package `fetch_pkg` holds:
  - opcode localparams;
  - the 7-state encoding;
  - byte and field widths.
- One natural sub-module, `instr_byte_assembler`: four 8-bit capture registers with a 2-bit write index, clear on `rst`, producing opcode/field/payload.
- The FSM stays in the top module.

## Test plan
Bench instantiates `program_counter_v1` plus a 256-byte behavioural memory indexed by `mem_addr`.
- Reset:
  - Assert `rst` mid-F2 → next cycle: state F0, `instr_valid`=0, `mem_addr`=0x00.
  - After release, the first fetch reads addresses 0x00..0x03.
- NORMAL:
  - Memory 0x00..0x03 = 0x05,0xAA,0xBB,0xCC; `instr_ready`=1.
  - Required: `instr_valid` in cycle 5 with opcode 00, field 0x05, payload 0xAABBCC.
  - `update_msbs` pulses for one cycle; the next fetch starts at 0x04.
- JUMP:
  - byte0 = 0x4F.
  - Required: `jump`=1 for one cycle with `jump_destination`=0x0F; next fetch at 0x3C.
- BRANCH:
  - byte0 = 0xBF (offset −1).
  - `branch_cond`=1 → one `branch` pulse with `branch_offset`=0x3F.
  - `branch_cond`=0 → `update_msbs` pulse instead, never `branch`.
- Backpressure:
  - Hold `instr_ready`=0 for 5 cycles.
  - Required: `instr_valid` stays 1, fields stay stable, `update_lsbs`/`update_msbs` stay 0, and `mem_addr` is unchanged.
- HALT:
  - byte0 = 0xC0.
  - Required: `halted`=1 and no PC pulses for 20 cycles.
  - `rst` clears `halted` and fetching resumes at 0x00.
